// File: rtl/up_seq.sv
// Micro-sequencer driving a 4 x DATA_W dual-read/dual-write register file from a 16-bit instruction stream.
// Optional flag registers are built only when UP_SEQ_FLAGS_EN is defined; otherwise flag_z/flag_c tie to 0.
module up_seq #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [1:0]        rf_sel_out_a,
    output logic [1:0]        rf_sel_out_b,
    input  logic [DATA_W-1:0] rf_data_out_a,
    input  logic [DATA_W-1:0] rf_data_out_b,
    output logic [1:0]        rf_sel_write_a,
    output logic [1:0]        rf_sel_write_b,
    output logic              rf_we_a,
    output logic              rf_we_b,
    output logic [DATA_W-1:0] rf_data_in_a,
    output logic [DATA_W-1:0] rf_data_in_b,
    output logic              done,
    output logic              illegal,
    output logic              flag_z,
    output logic              flag_c
);

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned SEL_W   = 2;

    localparam logic [OP_W-1:0] OP_NOP  = 4'd0;
    localparam logic [OP_W-1:0] OP_MOV  = 4'd1;
    localparam logic [OP_W-1:0] OP_ADD  = 4'd2;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd3;
    localparam logic [OP_W-1:0] OP_AND  = 4'd4;
    localparam logic [OP_W-1:0] OP_OR   = 4'd5;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd6;
    localparam logic [OP_W-1:0] OP_LDI  = 4'd7;
    localparam logic [OP_W-1:0] OP_SWAP = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;

    logic                 we_a_q, we_a_d;
    logic                 we_b_q, we_b_d;
    logic                 done_q, done_d;
    logic                 illegal_q, illegal_d;
    logic [SEL_W-1:0]     sel_wa_q, sel_wa_d;
    logic [SEL_W-1:0]     sel_wb_q, sel_wb_d;
    logic [DATA_W-1:0]    data_a_q, data_a_d;
    logic [DATA_W-1:0]    data_b_q, data_b_d;

    logic [OP_W-1:0]      opcode;
    logic [SEL_W-1:0]     rd, rs1, rs2;
    logic [DATA_W-1:0]    imm;
    logic                 is_swap;

    logic [DATA_W-1:0]    alu_res;
    logic                 wr_a, wr_b, legal;

    assign opcode  = instr_q[15:12];
    assign rd      = instr_q[11:10];
    assign rs1     = instr_q[9:8];
    assign rs2     = instr_q[7:6];
    assign imm     = DATA_W'(instr_q[7:0]);
    assign is_swap = (opcode == OP_SWAP);

    // State register
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= S_IDLE;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    // Next-state: accept in IDLE, then EXEC and WB unconditionally
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = S_EXEC;
                end
            end
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ALU and write-port decode from the latched instruction
    always_comb begin
        alu_res = '0;
        wr_a    = 1'b1;
        wr_b    = 1'b0;
        legal   = 1'b1;
        case (opcode)
            OP_NOP:  wr_a = 1'b0;
            OP_MOV:  alu_res = rf_data_out_a;
            OP_ADD:  alu_res = rf_data_out_a + rf_data_out_b;
            OP_SUB:  alu_res = rf_data_out_a - rf_data_out_b;
            OP_AND:  alu_res = rf_data_out_a & rf_data_out_b;
            OP_OR:   alu_res = rf_data_out_a | rf_data_out_b;
            OP_XOR:  alu_res = rf_data_out_a ^ rf_data_out_b;
            OP_LDI:  alu_res = imm;
            OP_SWAP: begin
                alu_res = rf_data_out_a;
                wr_b    = (rd != rs1);
            end
            default: begin
                wr_a  = 1'b0;
                legal = 1'b0;
            end
        endcase
    end

    // Outputs: read selects follow the latched instruction; write side is staged at EXEC
    always_comb begin
        instr_ready  = (state_q == S_IDLE);
        rf_sel_out_a = rs1;
        rf_sel_out_b = is_swap ? rd : rs2;
        we_a_d       = 1'b0;
        we_b_d       = 1'b0;
        done_d       = 1'b0;
        illegal_d    = 1'b0;
        sel_wa_d     = sel_wa_q;
        sel_wb_d     = sel_wb_q;
        data_a_d     = data_a_q;
        data_b_d     = data_b_q;
        if (state_q == S_EXEC) begin
            done_d    = legal;
            illegal_d = !legal;
            if (wr_a) begin
                we_a_d   = 1'b1;
                sel_wa_d = rd;
                data_a_d = alu_res;
            end
            if (wr_b) begin
                we_b_d   = 1'b1;
                sel_wb_d = rs1;
                data_b_d = rf_data_out_b;
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            we_a_q    <= 1'b0;
            we_b_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            sel_wa_q  <= '0;
            sel_wb_q  <= '0;
            data_a_q  <= '0;
            data_b_q  <= '0;
        end else begin
            we_a_q    <= we_a_d;
            we_b_q    <= we_b_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            sel_wa_q  <= sel_wa_d;
            sel_wb_q  <= sel_wb_d;
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
        end
    end

    assign rf_we_a        = we_a_q;
    assign rf_we_b        = we_b_q;
    assign done           = done_q;
    assign illegal        = illegal_q;
    assign rf_sel_write_a = sel_wa_q;
    assign rf_sel_write_b = sel_wb_q;
    assign rf_data_in_a   = data_a_q;
    assign rf_data_in_b   = data_b_q;

`ifdef UP_SEQ_FLAGS_EN
    logic flag_z_q, flag_z_d;
    logic flag_c_q, flag_c_d;

    // Carry of a truncated add shows up as the sum wrapping below an operand
    always_comb begin
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        if (state_q == S_EXEC) begin
            case (opcode)
                OP_ADD: begin
                    flag_z_d = (alu_res == '0);
                    flag_c_d = (alu_res < rf_data_out_a);
                end
                OP_SUB: begin
                    flag_z_d = (alu_res == '0);
                    flag_c_d = (rf_data_out_a < rf_data_out_b);
                end
                OP_AND, OP_OR, OP_XOR: begin
                    flag_z_d = (alu_res == '0);
                    flag_c_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
`else
    assign flag_z = 1'b0;
    assign flag_c = 1'b0;
`endif

endmodule

// File: tb/tb_up_seq.sv
// Bench for up_seq: bench-side register file, behavioural instruction model and per-cycle compare.
module tb_up_seq;

`ifdef UP_SEQ_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nRst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = 16'h0;
    logic [1:0]  rf_sel_out_a, rf_sel_out_b, rf_sel_write_a, rf_sel_write_b;
    logic [7:0]  rf_data_out_a, rf_data_out_b, rf_data_in_a, rf_data_in_b;
    logic        rf_we_a, rf_we_b, done, illegal, flag_z, flag_c;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    up_seq #(.DATA_W(8)) dut (
        .clk(clk), .nRst(nRst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .rf_sel_out_a(rf_sel_out_a), .rf_sel_out_b(rf_sel_out_b),
        .rf_data_out_a(rf_data_out_a), .rf_data_out_b(rf_data_out_b),
        .rf_sel_write_a(rf_sel_write_a), .rf_sel_write_b(rf_sel_write_b),
        .rf_we_a(rf_we_a), .rf_we_b(rf_we_b),
        .rf_data_in_a(rf_data_in_a), .rf_data_in_b(rf_data_in_b),
        .done(done), .illegal(illegal), .flag_z(flag_z), .flag_c(flag_c)
    );

    // Register file the sequencer drives; reset contents r0..r3 = 1..4
    logic [7:0] rf [4];
    assign rf_data_out_a = rf[rf_sel_out_a];
    assign rf_data_out_b = rf[rf_sel_out_b];

    always @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rf[0] <= 8'd1; rf[1] <= 8'd2; rf[2] <= 8'd3; rf[3] <= 8'd4;
        end else begin
            if (rf_we_a) rf[rf_sel_write_a] <= rf_data_in_a;
            if (rf_we_b) rf[rf_sel_write_b] <= rf_data_in_b;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Behavioural model: phase 0 = waiting, 1 = operands read, 2 = write cycle
    int         m_ph = 0;
    logic [15:0] m_ins = 16'h0;
    logic [7:0] m_rf [4];
    bit         m_z = 1'b0, m_c = 1'b0;
    bit         e_wa = 1'b0, e_wb = 1'b0, e_done = 1'b0, e_ill = 1'b0;
    logic [1:0] e_sa = 2'd0, e_sb = 2'd0;
    logic [7:0] e_da = 8'd0, e_db = 8'd0;

    always @(posedge clk or negedge nRst) begin : model
        int a, b, r, op, d, s1, s2;
        if (!nRst) begin
            m_ph = 0; m_ins = 16'h0; m_z = 1'b0; m_c = 1'b0;
            m_rf[0] = 8'd1; m_rf[1] = 8'd2; m_rf[2] = 8'd3; m_rf[3] = 8'd4;
            e_wa = 1'b0; e_wb = 1'b0; e_done = 1'b0; e_ill = 1'b0;
        end else if (m_ph == 0) begin
            if (instr_valid) begin
                m_ins = instr;
                m_ph  = 1;
            end
        end else if (m_ph == 1) begin
            op = int'(m_ins[15:12]); d = int'(m_ins[11:10]);
            s1 = int'(m_ins[9:8]);   s2 = int'(m_ins[7:6]);
            a  = int'(m_rf[s1]);     b  = int'(m_rf[s2]);
            r  = 0;
            e_done = (op <= 8);
            e_ill  = (op > 8);
            case (op)
                1: r = a;
                2: begin r = (a + b) % 256; m_z = (r == 0); m_c = (a + b) > 255; end
                3: begin r = (a - b + 256) % 256; m_z = (r == 0); m_c = (a < b); end
                4: begin r = a & b; m_z = (r == 0); m_c = 1'b0; end
                5: begin r = a | b; m_z = (r == 0); m_c = 1'b0; end
                6: begin r = a ^ b; m_z = (r == 0); m_c = 1'b0; end
                7: r = int'(m_ins[7:0]);
                8: begin
                    r = a;
                    if (d != s1) begin
                        e_wb = 1'b1; e_sb = 2'(s1); e_db = m_rf[d];
                    end
                end
                default: r = 0;
            endcase
            if (op >= 1 && op <= 8) begin
                e_wa = 1'b1; e_sa = 2'(d); e_da = 8'(r);
            end
            m_ph = 2;
        end else begin
            if (e_wa) m_rf[e_sa] = e_da;
            if (e_wb) m_rf[e_sb] = e_db;
            e_wa = 1'b0; e_wb = 1'b0; e_done = 1'b0; e_ill = 1'b0;
            m_ph = 0;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (!nRst) begin
            check("rst_ctrl", 32'({rf_we_a, rf_we_b, done, illegal, flag_z, flag_c}), 32'h0);
            check("rst_sel", 32'({rf_sel_write_a, rf_sel_write_b, rf_sel_out_a}), 32'h0);
            check("rst_data", 32'({rf_data_in_a, rf_data_in_b}), 32'h0);
        end else begin
            check("ready", 32'(instr_ready), 32'(m_ph == 0));
            check("we", 32'({rf_we_a, rf_we_b}), 32'({e_wa, e_wb}));
            check("done_ill", 32'({done, illegal}), 32'({e_done, e_ill}));
            check("flags", 32'({flag_z, flag_c}), 32'({m_z & FLAGS_ON, m_c & FLAGS_ON}));
            if (e_wa) check("port_a", 32'({rf_sel_write_a, rf_data_in_a}), 32'({e_sa, e_da}));
            if (e_wb) check("port_b", 32'({rf_sel_write_b, rf_data_in_b}), 32'({e_sb, e_db}));
            if (m_ph == 1)
                check("sel_out", 32'({rf_sel_out_a, rf_sel_out_b}),
                      32'({m_ins[9:8], (m_ins[15:12] == 4'd8) ? m_ins[11:10] : m_ins[7:6]}));
            check("rf", 32'({rf[3], rf[2], rf[1], rf[0]}),
                  32'({m_rf[3], m_rf[2], m_rf[1], m_rf[0]}));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        nRst = 1'b0;
        repeat (2) step();
        nRst = 1'b1;
    endtask

    // Offer one instruction until accepted; returns in the operand-read cycle
    task automatic issue(input logic [15:0] ins);
        bit acc;
        acc = 1'b0;
        instr = ins;
        instr_valid = 1'b1;
        for (int n = 0; n < 8; n++) begin
            acc = instr_ready;
            step();
            if (acc) break;
        end
        check("accept", 32'(acc), 32'h1);
        instr_valid = 1'b0;
        instr = 16'($urandom);
    endtask

    task automatic run(input logic [15:0] ins);
        issue(ins);
        repeat (2) step();
    endtask

    initial begin
        logic [8:0] rdy;
        logic [3:0] op;
        #1 nRst = 1'b0;
        repeat (2) step();
        nRst = 1'b1;
        check("ready_after_rst", 32'(instr_ready), 32'h1);

        run({4'h2, 2'd3, 2'd1, 2'd2, 6'd0});                 // ADD r3 = r1 + r2
        check("add_r3", 32'(rf[3]), 32'h05);
        check("add_flags", 32'({flag_z, flag_c}), 32'h0);

        do_reset();
        run({4'h3, 2'd0, 2'd0, 2'd3, 6'd0});                 // SUB r0 = 1 - 4
        check("sub_r0", 32'(rf[0]), 32'hFD);
        check("sub_flags", 32'({flag_z, flag_c}), 32'({1'b0, FLAGS_ON}));

        do_reset();
        run({4'h7, 2'd2, 2'd0, 8'hFF});                      // LDI r2 = FF
        run({4'h2, 2'd2, 2'd2, 2'd0, 6'd0});                 // ADD r2 = FF + 1
        check("add_wrap_r2", 32'(rf[2]), 32'h00);
        check("add_wrap_flags", 32'({flag_z, flag_c}), 32'({FLAGS_ON, FLAGS_ON}));

        run({4'hF, 12'h000});                                // illegal opcode
        check("ill_rf", 32'({rf[3], rf[2], rf[1], rf[0]}), 32'h04000201);
        check("ill_flags", 32'({flag_z, flag_c}), 32'({FLAGS_ON, FLAGS_ON}));

        instr = {4'h2, 2'd3, 2'd0, 2'd1, 6'd0};
        instr_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rdy[i] = instr_ready;
            step();
        end
        instr_valid = 1'b0;
        check("ready_pattern", 32'(rdy), 32'h049);
        repeat (2) step();

        do_reset();
        run({4'h8, 2'd0, 2'd3, 8'h00});                      // SWAP r0 <-> r3
        check("swap_r0_r3", 32'({rf[3], rf[0]}), 32'h0104);
        run({4'h8, 2'd1, 2'd1, 8'h00});                      // SWAP r1 with itself
        check("swap_self_r1", 32'(rf[1]), 32'h02);

        do_reset();
        issue({4'h2, 2'd3, 2'd1, 2'd2, 6'd0});               // reset during operand read
        nRst = 1'b0;
        repeat (2) step();
        nRst = 1'b1;
        step();
        check("rst_exec_ready", 32'(instr_ready), 32'h1);
        check("rst_exec_r3", 32'(rf[3]), 32'h04);

        for (int k = 0; k < 400; k++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) op = 4'($urandom_range(0, 8));
            repeat ($urandom_range(0, 2)) begin
                instr = 16'($urandom);
                step();
            end
            issue({op, 12'($urandom)});
            if ($urandom_range(0, 39) == 0) begin
                nRst = 1'b0;
                step();
                nRst = 1'b1;
            end
        end
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/up_seq.md
Name: up_seq

Overview:
- Micro-sequencer that drives the 4 x 8-bit dual-read/dual-write register file (up) from a stream of 16-bit instructions.
- Accepts one instruction per valid/ready handshake, reads operands through the two read ports, and computes in an internal ALU.
- Writes results back through write port A; SWAP also uses write port B.
- Sits between the instruction source and the register file; it is the only master of the register file ports.

Parameters:
- DATA_W, 8, datapath width; must equal register file width (only 8 supported).

Ports:
- clk  in  1  clock, rising edge.
- nRst  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept.
- instr  in  16  [15:12] opcode, [11:10] rd, [9:8] rs1, [7:6] rs2, [7:0] imm (LDI).
- rf_sel_out_a  out  2  read port A select.
- rf_sel_out_b  out  2  read port B select.
- rf_data_out_a  in  DATA_W  read port A data (combinational from register file).
- rf_data_out_b  in  DATA_W  read port B data.
- rf_sel_write_a  out  2  write port A select.
- rf_sel_write_b  out  2  write port B select.
- rf_we_a  out  1  write enable A.
- rf_we_b  out  1  write enable B.
- rf_data_in_a  out  DATA_W  write data A.
- rf_data_in_b  out  DATA_W  write data B.
- done  out  1  one-cycle pulse in writeback.
- illegal  out  1  one-cycle pulse for an undefined opcode.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry/borrow flag.

Behaviour:

Reset (nRst low, any state):
- State goes to IDLE.
- rf_we_a, rf_we_b, done, illegal, flag_z, flag_c = 0.
- Selects, data_in outputs and the latched instruction = 0.
- instr_ready = 1 once nRst is high.
- An instruction in flight is dropped with no write.

FSM, one instruction per 3 cycles:
- IDLE: instr_ready = 1. When instr_valid is high, latch instr and go to EXEC.
- EXEC: instr_ready = 0.
  - rf_sel_out_a = rs1.
  - rf_sel_out_b = rs2, except SWAP uses rd.
  - Compute result into a register; capture the rf_data_out_b copy for SWAP.
  - Update flags. Go to WB.
- WB: instr_ready = 0. Drive the write and pulse done or illegal, then go to IDLE.
  - rf_we_a = 1, rf_sel_write_a = rd, rf_data_in_a = result.
  - SWAP only: rf_we_b = 1, rf_sel_write_b = rs1, rf_data_in_b = old rd value.
- rf_we_a and rf_we_b are asserted only in WB. Outside WB, write selects and data hold their last value.

Opcodes:
- 0 NOP: no write; done pulses.
- 1 MOV: rd = rs1.
- 2 ADD: rd = rs1 + rs2, mod 256.
- 3 SUB: rd = rs1 - rs2, mod 256.
- 4 AND, 5 OR, 6 XOR: rd = rs1 op rs2.
- 7 LDI: rd = imm; no read is needed.
- 8 SWAP: rd and rs1 exchange values in the same WB cycle.
- 9-15: illegal. No write; illegal pulses in WB and done stays 0.

Flags:
- Updated at the EXEC->WB edge only by ADD, SUB, AND, OR and XOR.
- flag_z = (result == 0).
- flag_c:
  - ADD: carry out of bit 7.
  - SUB: borrow, i.e. rs1 < rs2 unsigned.
  - AND/OR/XOR: cleared to 0.
- MOV, LDI, SWAP, NOP and illegal opcodes leave the flags unchanged.

Boundary conditions:
- SWAP with rd == rs1: rf_we_b is suppressed, so only a port A write of the unchanged value occurs. No port collision.
- rd equal to rs1 or rs2: operands are read in EXEC before the WB write, so old values are used.
- instr_valid held high continuously: accepted every 3rd cycle, only in IDLE.
- instr may change while not ready; only the value at the handshake is used.

Optional Feature:
- Macro UP_SEQ_FLAGS_EN.
- Defined: flag_z and flag_c behave as specified above.
- Undefined: flag registers are not built and flag_z = flag_c = 0 constantly. All other behaviour is unchanged.

Test Plan:
- Register file at reset contents r0=1, r1=2, r2=3, r3=4; issue ADD rd=3, rs1=1, rs2=2 -> r3 = 0x05 after WB, done pulses once, flag_z = 0, flag_c = 0.
- SUB rd=0, rs1=0, rs2=3 (1 - 4) -> r0 = 0xFD, flag_c = 1, flag_z = 0; with UP_SEQ_FLAGS_EN undefined, both flags stay 0.
- LDI rd=2, imm=0xFF, then ADD rd=2, rs1=2, rs2=0 -> r2 = 0x00, flag_z = 1, flag_c = 1.
- SWAP rd=0, rs1=3 from reset -> r0 = 4 and r3 = 1, with rf_we_a and rf_we_b high in the same single cycle; SWAP rd=1, rs1=1 -> only rf_we_a asserted, r1 unchanged.
- Opcode 0xF -> illegal pulses once, done stays 0, no write enable, flags unchanged; instr_valid held high for 3 instructions -> instr_ready high on cycles 0, 3 and 6 only.
- nRst low during EXEC of ADD rd=3 -> no write enable at any point, outputs at reset values, instr_ready = 1 on the first cycle after release.
